// File: rtl/cfg_frame_pkg.sv
// cfg_frame_pkg
// Shared definitions for the configuration frame writer:
//   - cfg_state_e        : writer session state
//   - DEFAULT_SYNC_WORD  : word that opens a configuration session
//   - DESYNC_COL         : header column code that ends a session
//   - HDR_*              : bit positions of the header fields
package cfg_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_SKIP   = 3'd3,
        ST_SETUP  = 3'd4,
        ST_PULSE  = 3'd5,
        ST_HOLD   = 3'd6
    } cfg_state_e;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;
    localparam logic [7:0]  DESYNC_COL        = 8'hFF;

    // Header layout: column in the top byte, frame index in a 5-bit field below it.
    localparam int HDR_COL_MSB   = 31;
    localparam int HDR_COL_LSB   = 24;
    localparam int HDR_FRAME_MSB = 20;
    localparam int HDR_FRAME_LSB = 16;

endpackage

// File: rtl/cfg_onehot_dec.sv
// cfg_onehot_dec
// Binary index to one-hot decoder with enable; used for both the column
// select and the frame strobe of the frame writer.
// Ports:
//   idx_i    : binary index (IDX_W bits)
//   en_i     : when low the output is all zeros
//   onehot_o : WIDTH-bit one-hot result (zero if idx_i >= WIDTH)
module cfg_onehot_dec #(
    parameter int WIDTH = 16,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (en_i && (idx_i == IDX_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_frame_writer.sv
// cfg_frame_writer
// Assembles configuration frames from a 32-bit word stream and drives the
// fabric config latches with a setup / pulse / hold sequence so the latch
// enables (ColSelect & FrameStrobe) never overlap a data change.
// Ports:
//   CLK, resetn    : clock, asynchronous active-low reset
//   word_i         : incoming configuration word
//   word_valid_i   : word_i valid; transfer = valid & word_ready_o
//   word_ready_o   : writer can accept a word this cycle
//   FrameData_o    : assembled frame, row k at [k*32 +: 32]
//   ColSelect_o    : one-hot column select (SETUP..HOLD)
//   FrameStrobe_o  : one-hot frame strobe, high only in PULSE
//   busy_o         : session active
//   err_o          : sticky bad-frame-address flag
//   frames_done_o  : frames strobed since reset (wraps)
module cfg_frame_writer
    import cfg_frame_pkg::*;
#(
    parameter int          ROWS           = 16,
    parameter int          COLUMNS        = 16,
    parameter int          FRAMES_PER_COL = 20,
    parameter logic [31:0] SYNC_WORD      = DEFAULT_SYNC_WORD
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic [31:0]               word_i,
    input  logic                      word_valid_i,
    output logic                      word_ready_o,
    output logic [ROWS*32-1:0]        FrameData_o,
    output logic [COLUMNS-1:0]        ColSelect_o,
    output logic [FRAMES_PER_COL-1:0] FrameStrobe_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [15:0]               frames_done_o
);

    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W   = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int FRAME_W = (FRAMES_PER_COL > 1) ? $clog2(FRAMES_PER_COL) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    cfg_state_e                state_q, state_d;
    logic [ROW_W-1:0]          row_cnt_q, row_cnt_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [FRAME_W-1:0]        frame_q, frame_d;
    logic [ROWS*32-1:0]        frame_data_q, frame_data_d;
    logic [COLUMNS-1:0]        col_sel_q, col_sel_d;
    logic [FRAMES_PER_COL-1:0] strobe_q, strobe_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      err_q, err_d;
    logic [15:0]               frames_done_q, frames_done_d;

    logic                      xfer;
    logic [7:0]                hdr_col;
    logic [4:0]                hdr_frame;
    logic                      hdr_bad;
    logic                      col_en_d;
    logic                      strobe_en_d;

    assign xfer      = word_valid_i & ready_q;
    assign hdr_col   = word_i[HDR_COL_MSB:HDR_COL_LSB];
    assign hdr_frame = word_i[HDR_FRAME_MSB:HDR_FRAME_LSB];
    assign hdr_bad   = ({24'd0, hdr_col} >= 32'(COLUMNS)) ||
                       ({27'd0, hdr_frame} >= 32'(FRAMES_PER_COL));

    // Next-state and datapath. Selects are decoded from the *next* state so
    // they land in their flops on the same edge the state changes, keeping
    // every output registered.
    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        col_d         = col_q;
        frame_d       = frame_q;
        frame_data_d  = frame_data_q;
        err_d         = err_q;
        frames_done_d = frames_done_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer && (word_i == SYNC_WORD)) begin
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    row_cnt_d = '0;
                    if (hdr_col == DESYNC_COL) begin
                        state_d = ST_IDLE;
                    end else if (hdr_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_SKIP;
                    end else begin
                        col_d   = hdr_col[COL_W-1:0];
                        frame_d = hdr_frame[FRAME_W-1:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (row_cnt_q == ROW_W'(r)) begin
                            frame_data_d[r*32 +: 32] = word_i;
                        end
                    end
                    if (row_cnt_q == LAST_ROW) begin
                        row_cnt_d = '0;
                        state_d   = ST_SETUP;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                // Payload of a rejected frame is swallowed without touching the frame buffer.
                if (xfer) begin
                    if (row_cnt_q == LAST_ROW) begin
                        row_cnt_d = '0;
                        state_d   = ST_HEADER;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            ST_SETUP: state_d = ST_PULSE;
            ST_PULSE: state_d = ST_HOLD;
            ST_HOLD: begin
                frames_done_d = frames_done_q + 16'd1;
                state_d       = ST_HEADER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output enables derived from where the FSM is going next.
    always_comb begin
        col_en_d    = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
        strobe_en_d = (state_d == ST_PULSE);
        ready_d     = (state_d == ST_IDLE) || (state_d == ST_HEADER) ||
                      (state_d == ST_DATA) || (state_d == ST_SKIP);
        busy_d      = (state_d != ST_IDLE);
    end

    cfg_onehot_dec #(
        .WIDTH (COLUMNS),
        .IDX_W (COL_W)
    ) u_col_dec (
        .idx_i    (col_d),
        .en_i     (col_en_d),
        .onehot_o (col_sel_d)
    );

    cfg_onehot_dec #(
        .WIDTH (FRAMES_PER_COL),
        .IDX_W (FRAME_W)
    ) u_frame_dec (
        .idx_i    (frame_d),
        .en_i     (strobe_en_d),
        .onehot_o (strobe_d)
    );

    // Single state/output register. The async reset clears the latch enables
    // immediately, even in the middle of a strobe pulse.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            row_cnt_q     <= '0;
            col_q         <= '0;
            frame_q       <= '0;
            frame_data_q  <= '0;
            col_sel_q     <= '0;
            strobe_q      <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            frames_done_q <= '0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            col_q         <= col_d;
            frame_q       <= frame_d;
            frame_data_q  <= frame_data_d;
            col_sel_q     <= col_sel_d;
            strobe_q      <= strobe_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            frames_done_q <= frames_done_d;
        end
    end

    assign word_ready_o  = ready_q;
    assign FrameData_o   = frame_data_q;
    assign ColSelect_o   = col_sel_q;
    assign FrameStrobe_o = strobe_q;
    assign busy_o        = busy_q;
    assign err_o         = err_q;
    assign frames_done_o = frames_done_q;

endmodule

// File: tb/tb_cfg_frame_writer.sv
// tb_cfg_frame_writer
// Directed bench for cfg_frame_writer: sync/junk handling, normal frame with
// setup/pulse/hold timing, bad header skip with sticky error, desync, stalled
// data phase, and asynchronous reset during the strobe pulse.
module tb_cfg_frame_writer;

    localparam int ROWS = 16;
    localparam int COLUMNS = 16;
    localparam int FPC = 20;
    localparam int FW = ROWS * 32;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic              CLK = 1'b0;
    logic              resetn;
    logic [31:0]       word_i;
    logic              word_valid_i;
    logic              word_ready_o;
    logic [FW-1:0]     FrameData_o;
    logic [COLUMNS-1:0] ColSelect_o;
    logic [FPC-1:0]    FrameStrobe_o;
    logic              busy_o;
    logic              err_o;
    logic [15:0]       frames_done_o;

    int vectorCount = 0;
    int miscompareCount = 0;
    int strobeCycles = 0;

    logic [FW-1:0] expFrame;
    logic [31:0]   dataWords [ROWS];

    cfg_frame_writer #(
        .ROWS           (ROWS),
        .COLUMNS        (COLUMNS),
        .FRAMES_PER_COL (FPC),
        .SYNC_WORD      (SYNC)
    ) dut (
        .CLK           (CLK),
        .resetn        (resetn),
        .word_i        (word_i),
        .word_valid_i  (word_valid_i),
        .word_ready_o  (word_ready_o),
        .FrameData_o   (FrameData_o),
        .ColSelect_o   (ColSelect_o),
        .FrameStrobe_o (FrameStrobe_o),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .frames_done_o (frames_done_o)
    );

    always #5 CLK = ~CLK;

    // Count cycles in which any strobe bit is seen high, sampled mid-cycle.
    always @(negedge CLK) begin
        if (FrameStrobe_o != '0) strobeCycles++;
    end

    task automatic checkOutput(input string tag, input logic [FW-1:0] actual, input logic [FW-1:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    // Offer one word and wait (bounded) until it is accepted.
    task automatic applyStimulus(input logic [31:0] w);
        logic rdy;
        logic accepted;
        accepted = 1'b0;
        word_i = w;
        word_valid_i = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            rdy = word_ready_o;
            stepCycle();
            accepted = rdy;
        end
        word_valid_i = 1'b0;
        if (!accepted) checkOutput("handshake_timeout", '0, 1);
    endtask

    // Header followed by dataWords; optional 5-cycle valid gap after word gapAfter.
    task automatic sendFrame(input logic [31:0] hdr, input int gapAfter);
        applyStimulus(hdr);
        for (int k = 0; k < ROWS; k++) begin
            applyStimulus(dataWords[k]);
            if (k == gapAfter) begin
                for (int g = 0; g < 5; g++) begin
                    stepCycle();
                    checkOutput("stall_ready", FW'(word_ready_o), 1);
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        word_i = '0;
        word_valid_i = 1'b0;
        expFrame = '0;
        repeat (3) @(posedge CLK);
        #1;
        resetn = 1'b1;
        stepCycle();

        // Reset state
        checkOutput("rst_ready", FW'(word_ready_o), 1);
        checkOutput("rst_busy", FW'(busy_o), 0);
        checkOutput("rst_err", FW'(err_o), 0);
        checkOutput("rst_frames", FW'(frames_done_o), 0);
        checkOutput("rst_col", FW'(ColSelect_o), 0);
        checkOutput("rst_strobe", FW'(FrameStrobe_o), 0);
        checkOutput("rst_data", FrameData_o, '0);

        // Junk before sync is discarded
        applyStimulus(32'h1234_5678);
        applyStimulus(32'h1234_5678);
        checkOutput("junk_busy", FW'(busy_o), 0);
        applyStimulus(SYNC);
        checkOutput("sync_busy", FW'(busy_o), 1);

        // Normal frame: col 2, frame 3
        for (int k = 0; k < ROWS; k++) begin
            dataWords[k] = 32'h1000_0000 + 32'(k);
            expFrame[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        end
        sendFrame(32'h0203_0000, -1);
        checkOutput("f1_setup_col", FW'(ColSelect_o), 16'h0004);
        checkOutput("f1_setup_strobe", FW'(FrameStrobe_o), 0);
        checkOutput("f1_setup_ready", FW'(word_ready_o), 0);
        checkOutput("f1_setup_data", FrameData_o, expFrame);
        stepCycle();
        checkOutput("f1_pulse_col", FW'(ColSelect_o), 16'h0004);
        checkOutput("f1_pulse_strobe", FW'(FrameStrobe_o), 20'h00008);
        checkOutput("f1_pulse_ready", FW'(word_ready_o), 0);
        stepCycle();
        checkOutput("f1_hold_col", FW'(ColSelect_o), 16'h0004);
        checkOutput("f1_hold_strobe", FW'(FrameStrobe_o), 0);
        checkOutput("f1_hold_data", FrameData_o, expFrame);
        stepCycle();
        checkOutput("f1_hdr_col", FW'(ColSelect_o), 0);
        checkOutput("f1_hdr_ready", FW'(word_ready_o), 1);
        checkOutput("f1_frames", FW'(frames_done_o), 1);
        checkOutput("f1_strobe_cycles", FW'(strobeCycles), 1);

        // Bad column: skipped, sticky error, data untouched
        for (int k = 0; k < ROWS; k++) dataWords[k] = 32'hDEAD_0000 + 32'(k);
        sendFrame(32'h1000_0000, -1);
        checkOutput("bad_err", FW'(err_o), 1);
        checkOutput("bad_busy", FW'(busy_o), 1);
        checkOutput("bad_data", FrameData_o, expFrame);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("bad_strobe_cycles", FW'(strobeCycles), 1);
        checkOutput("bad_col", FW'(ColSelect_o), 0);

        // Valid frame after error, col 15 frame 19, sync word as data, stall mid-DATA
        for (int k = 0; k < ROWS; k++) begin
            dataWords[k] = (k == 0) ? SYNC : 32'h2000_0000 + 32'(k);
            expFrame[k*32 +: 32] = dataWords[k];
        end
        sendFrame(32'h0F13_0000, 7);
        checkOutput("f2_setup_col", FW'(ColSelect_o), 16'h8000);
        stepCycle();
        checkOutput("f2_pulse_strobe", FW'(FrameStrobe_o), 20'h80000);
        stepCycle();
        stepCycle();
        checkOutput("f2_frames", FW'(frames_done_o), 2);
        checkOutput("f2_err_sticky", FW'(err_o), 1);
        checkOutput("f2_data", FrameData_o, expFrame);
        checkOutput("f2_strobe_cycles", FW'(strobeCycles), 2);

        // Desync: back to IDLE, following frame-looking words ignored
        applyStimulus(32'hFF00_0000);
        checkOutput("desync_busy", FW'(busy_o), 0);
        applyStimulus(32'h0203_0000);
        for (int k = 0; k < ROWS; k++) applyStimulus(32'h5555_0000 + 32'(k));
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("desync_busy2", FW'(busy_o), 0);
        checkOutput("desync_data", FrameData_o, expFrame);
        checkOutput("desync_strobe_cycles", FW'(strobeCycles), 2);
        checkOutput("desync_frames", FW'(frames_done_o), 2);

        // Reset in the middle of the strobe pulse
        applyStimulus(SYNC);
        for (int k = 0; k < ROWS; k++) dataWords[k] = 32'h3000_0000 + 32'(k);
        sendFrame(32'h0101_0000, -1);
        checkOutput("f3_setup_col", FW'(ColSelect_o), 16'h0002);
        stepCycle();
        checkOutput("f3_pulse_strobe", FW'(FrameStrobe_o), 20'h00002);
        resetn = 1'b0;
        #1;
        checkOutput("arst_strobe", FW'(FrameStrobe_o), 0);
        checkOutput("arst_col", FW'(ColSelect_o), 0);
        checkOutput("arst_data", FrameData_o, '0);
        checkOutput("arst_busy", FW'(busy_o), 0);
        checkOutput("arst_frames", FW'(frames_done_o), 0);
        checkOutput("arst_err", FW'(err_o), 0);
        @(negedge CLK);
        resetn = 1'b1;
        stepCycle();
        applyStimulus(32'h0203_0000);
        checkOutput("post_rst_needs_sync", FW'(busy_o), 0);
        applyStimulus(SYNC);
        checkOutput("post_rst_sync", FW'(busy_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule

// File: doc/cfg_frame_writer.md
Name: cfg_frame_writer

Overview:
- Configuration-side driver for the fabric's config latches: consumes a 32-bit configuration word stream and assembles full frames.
- Drives frame data, a one-hot column select and a one-hot frame strobe; the strobe feeds the latch enable inputs (tile-level enable = ColSelect & FrameStrobe).
- Sits between the bitstream source (UART/JTAG/host bridge) and the fabric frame distribution network.
- Sequences setup/pulse/hold so latch enables never overlap a data change.

Parameters:
- ROWS, 16, fabric tile rows; one 32-bit word per row per frame
- COLUMNS, 16, fabric columns; width of ColSelect_o
- FRAMES_PER_COL, 20, frames per column; width of FrameStrobe_o
- SYNC_WORD, 32'hFAB0_FAB1, word that starts a configuration session

Ports:
- CLK  in  1  single clock
- resetn  in  1  asynchronous active-low reset
- word_i  in  32  configuration word
- word_valid_i  in  1  word_i valid
- word_ready_o  out  1  writer accepts word this cycle (transfer = valid & ready)
- FrameData_o  out  ROWS*32  frame data; row k at [k*32 +: 32]
- ColSelect_o  out  COLUMNS  one-hot column select
- FrameStrobe_o  out  FRAMES_PER_COL  one-hot frame strobe (latch enable)
- busy_o  out  1  session active (state != IDLE)
- err_o  out  1  sticky: bad frame address seen
- frames_done_o  out  16  count of frames strobed since reset, wraps at 2^16

Behaviour:
- Reset (async assert, sync deassert, any state): state=IDLE; all outputs 0 except word_ready_o=1; FrameData_o cleared; counters cleared; err_o cleared.
- States: IDLE, HEADER, DATA, SKIP, SETUP, PULSE, HOLD.
- IDLE: ready=1; accepted word == SYNC_WORD -> HEADER; any other word discarded.
- HEADER: ready=1; header fields col=[31:24], frame=[20:16], other bits ignored.
  - col==8'hFF -> IDLE (desync), no strobe.
  - col>=COLUMNS or frame>=FRAMES_PER_COL -> set err_o; SKIP.
  - otherwise latch col/frame; row_cnt=0; DATA.
- DATA: ready=1; each accepted word written to FrameData_o[row_cnt*32 +: 32]; row_cnt++. After word ROWS-1 -> SETUP.
- SKIP: ready=1; discards ROWS words, FrameData_o unchanged, then HEADER.
- SETUP (1 cycle): ready=0; ColSelect_o one-hot at col; FrameStrobe_o=0.
- PULSE (1 cycle): ready=0; FrameStrobe_o one-hot at frame; ColSelect_o held.
- HOLD (1 cycle): ready=0; FrameStrobe_o=0; ColSelect_o held; frames_done_o++; -> HEADER with ColSelect_o=0.
- Invariants:
  - FrameData_o is stable from SETUP through HOLD.
  - FrameStrobe_o is high for exactly one cycle per valid frame.
  - At most one bit of each select output is set.
- Latency: last data word accepted at cycle t -> strobe high at t+2; next header accepted no earlier than t+4.
- Boundaries:
  - valid low mid-DATA stalls row_cnt with no timeout.
  - SYNC_WORD received in HEADER/DATA is treated as ordinary header/data.
  - frames_done_o wraps 16'hFFFF->0.
  - Reset during PULSE drops the strobe immediately (async).

Decomposition:
- Shared package cfg_frame_pkg:
  - state enum
  - SYNC_WORD default
  - DESYNC_COL=8'hFF
  - header field bit positions
- Natural sub-module: cfg_onehot_dec (binary index + enable -> one-hot, parameterised width), used for both ColSelect_o and FrameStrobe_o.

Test Plan:
- Sync + header 32'h0203_0000 + 16 words 32'h1000_0000+k -> FrameData_o row k = 32'h1000_0000+k; ColSelect_o=16'h0004 for 3 cycles; FrameStrobe_o=20'h00008 for exactly 1 cycle (the middle one); frames_done_o=1.
- Junk words 32'h1234_5678 before sync -> no state change, busy_o=0; then sync -> busy_o=1.
- Header col=16 (32'h1000_0000) + 16 words -> err_o=1, no strobe, FrameData_o unchanged; next valid frame writes normally, err_o stays 1.
- Header 32'hFF00_0000 -> IDLE, busy_o=0, no strobe; subsequent data words ignored until sync.
- valid deasserted for 5 cycles mid-DATA, then resumed -> same FrameData_o as with no gap; word_ready_o=0 only during SETUP/PULSE/HOLD.
- resetn low during PULSE -> FrameStrobe_o/ColSelect_o/FrameData_o=0 the same cycle; after release state IDLE and sync is required.
